// File: rtl/uart_rx_par_chk_if.sv
// Handshake bundle between the UART RX sampler/FSM and the bit-serial parity checker.
// The checker sits on the slave modport; the sampler side uses master.
interface uart_rx_par_chk_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              frame_start;
    logic [1:0]        PAR_TYPE;
    logic              par_en;
    logic              bit_valid;
    logic              sampled_bit;
    logic              clr_err;
    logic [DATA_W-1:0] P_Data;
    logic              chk_done;
    logic              par_err;
    logic              par_err_sticky;
    logic [CNT_W-1:0]  err_cnt;
    logic              busy;

    modport master (
        output frame_start, PAR_TYPE, par_en, bit_valid, sampled_bit, clr_err,
        input  P_Data, chk_done, par_err, par_err_sticky, err_cnt, busy
    );

    modport slave (
        input  frame_start, PAR_TYPE, par_en, bit_valid, sampled_bit, clr_err,
        output P_Data, chk_done, par_err, par_err_sticky, err_cnt, busy
    );
endinterface

// File: rtl/uart_rx_par_chk.sv
// Bit-serial UART RX parity checker: accumulates parity LSB first and checks the parity bit.
// Define UART_PAR_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module uart_rx_par_chk #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    uart_rx_par_chk_if.slave    bus
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    localparam logic [1:0] P_EVEN  = 2'd0;
    localparam logic [1:0] P_ODD   = 2'd1;
    localparam logic [1:0] P_MARK  = 2'd2;
    localparam logic [1:0] P_SPACE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     bitCnt_q, bitCnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] pData_q, pData_d;
    logic [1:0]        mode_q, mode_d;
    logic              parEn_q, parEn_d;
    logic              chkDone_q, chkDone_d;
    logic              parErr_q, parErr_d;
    logic              sticky_q, sticky_d;
    logic              expBit;
    logic              mismatch;

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        acc_d     = acc_q;
        pData_d   = pData_q;
        mode_d    = mode_q;
        parEn_d   = parEn_q;
        chkDone_d = 1'b0;
        parErr_d  = parErr_q;
        mismatch  = 1'b0;
        expBit    = 1'b0;

        // frame_start overrides everything, including a bit_valid in the same cycle
        if (bus.frame_start) begin
            mode_d   = bus.PAR_TYPE;
            parEn_d  = bus.par_en;
            acc_d    = 1'b0;
            bitCnt_d = '0;
            state_d  = S_DATA;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (bus.bit_valid) begin
                        acc_d            = acc_q ^ bus.sampled_bit;
                        pData_d[bitCnt_q] = bus.sampled_bit;
                        bitCnt_d         = bitCnt_q + CW'(1);
                        if (bitCnt_q == LAST_BIT) begin
                            if (parEn_q) begin
                                state_d = S_PARITY;
                            end else begin
                                state_d   = S_IDLE;
                                chkDone_d = 1'b1;
                                parErr_d  = 1'b0;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (bus.bit_valid) begin
                        case (mode_q)
                            P_EVEN:  expBit = acc_q;
                            P_ODD:   expBit = ~acc_q;
                            P_MARK:  expBit = 1'b1;
                            P_SPACE: expBit = 1'b0;
                            default: expBit = acc_q;
                        endcase
                        parErr_d  = bus.sampled_bit ^ expBit;
                        mismatch  = parErr_d;
                        chkDone_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // a new mismatch wins over a same-cycle clear
        sticky_d = bus.clr_err ? 1'b0 : sticky_q;
        if (mismatch) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bitCnt_q  <= '0;
            acc_q     <= 1'b0;
            pData_q   <= '0;
            mode_q    <= P_EVEN;
            parEn_q   <= 1'b0;
            chkDone_q <= 1'b0;
            parErr_q  <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            acc_q     <= acc_d;
            pData_q   <= pData_d;
            mode_q    <= mode_d;
            parEn_q   <= parEn_d;
            chkDone_q <= chkDone_d;
            parErr_q  <= parErr_d;
            sticky_q  <= sticky_d;
        end
    end

`ifdef UART_PAR_ERR_CNT_EN
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    // clear first, then count, so clear plus mismatch in one cycle leaves 1
    always_comb begin
        errCnt_d = bus.clr_err ? '0 : errCnt_q;
        if (mismatch && (errCnt_d != {CNT_W{1'b1}})) begin
            errCnt_d = errCnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign bus.err_cnt = errCnt_q;
`else
    assign bus.err_cnt = {CNT_W{1'b0}};
`endif

    assign bus.P_Data         = pData_q;
    assign bus.chk_done       = chkDone_q;
    assign bus.par_err        = parErr_q;
    assign bus.par_err_sticky = sticky_q;
    assign bus.busy           = (state_q == S_DATA) || (state_q == S_PARITY);

endmodule

// File: tb/tb_uart_rx_par_chk.sv
// Self-checking bench for uart_rx_par_chk: directed vector table, abort/saturation/reset sequences
// and randomized frames checked against a frame-level parity model.
module tb_uart_rx_par_chk;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [1:0] M_EVEN  = 2'd0;
    localparam logic [1:0] M_ODD   = 2'd1;
    localparam logic [1:0] M_MARK  = 2'd2;
    localparam logic [1:0] M_SPACE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_par_chk_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

    uart_rx_par_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic       mdlSticky;
    int         mdlCnt;
    logic [7:0] mdlData;

    typedef struct {
        logic [1:0] mode;
        logic       pen;
        logic [7:0] data;
        logic       pbit;
        logic       expErr;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic refErr(input logic [1:0] mode, input logic pen,
                                    input logic [7:0] data, input logic pbit);
        int   ones;
        logic want;
        ones = $countones(data);
        if (!pen) return 1'b0;
        case (mode)
            M_EVEN:  want = ones[0];
            M_ODD:   want = ~ones[0];
            M_MARK:  want = 1'b1;
            default: want = 1'b0;
        endcase
        return pbit != want;
    endfunction

    function automatic int expCnt();
`ifdef UART_PAR_ERR_CNT_EN
        return mdlCnt;
`else
        return 0;
`endif
    endfunction

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_sticky"}, bus.par_err_sticky, mdlSticky);
        checkOutput({tag, "_errcnt"}, bus.err_cnt, expCnt());
    endtask

    // One complete frame; doStart=0 means the caller has already issued frame_start
    task automatic applyStimulus(input logic [1:0] mode, input logic pen, input logic [7:0] data,
                                 input logic pbit, input logic expErr, input logic clrOnLast,
                                 input logic doStart, input string tag);
        int nbits;
        nbits = pen ? DATA_W + 1 : DATA_W;
        if (doStart) begin
            bus.frame_start = 1'b1;
            bus.PAR_TYPE    = mode;
            bus.par_en      = pen;
            @(negedge clk);
            bus.frame_start = 1'b0;
        end
        bus.PAR_TYPE = 2'($urandom);
        bus.par_en   = 1'($urandom);
        checkOutput({tag, "_busy"}, bus.busy, 1);
        for (int i = 0; i < nbits; i++) begin
            bus.bit_valid   = 1'b1;
            bus.sampled_bit = (i < DATA_W) ? data[i] : pbit;
            bus.clr_err     = (i == nbits - 1) ? clrOnLast : 1'b0;
            @(negedge clk);
            bus.bit_valid = 1'b0;
            bus.clr_err   = 1'b0;
            if (i < nbits - 1) begin
                checkOutput({tag, "_early"}, bus.chk_done, 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        if (clrOnLast) begin
            mdlSticky = 1'b0;
            mdlCnt    = 0;
        end
        if (expErr) begin
            mdlSticky = 1'b1;
            if (mdlCnt < CNT_MAX) mdlCnt++;
        end
        mdlData = data;
        checkOutput({tag, "_done"},  bus.chk_done, 1);
        checkOutput({tag, "_perr"},  bus.par_err, expErr);
        checkOutput({tag, "_pdata"}, bus.P_Data, data);
        checkOutput({tag, "_idle"},  bus.busy, 0);
        checkStatus(tag);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, bus.chk_done, 0);
        checkOutput({tag, "_hold"},  bus.par_err, expErr);
    endtask

    task automatic pulseClr(input string tag);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        mdlSticky = 1'b0;
        mdlCnt    = 0;
        checkStatus(tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] m;
        logic       p, pb, ce;
        logic [7:0] d;

        vecs[0] = '{M_EVEN,  1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{M_ODD,   1'b1, 8'h0F, 1'b0, 1'b1};
        vecs[2] = '{M_ODD,   1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[3] = '{M_MARK,  1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{M_SPACE, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{M_EVEN,  1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{M_EVEN,  1'b1, 8'h01, 1'b0, 1'b1};
        vecs[7] = '{M_ODD,   1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{M_MARK,  1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{M_SPACE, 1'b1, 8'h81, 1'b1, 1'b1};

        bus.frame_start = 1'b0;
        bus.PAR_TYPE    = 2'd0;
        bus.par_en      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.sampled_bit = 1'b0;
        bus.clr_err     = 1'b0;
        mdlSticky = 1'b0;
        mdlCnt    = 0;
        mdlData   = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("rst_done",   bus.chk_done, 0);
        checkOutput("rst_perr",   bus.par_err, 0);
        checkOutput("rst_pdata",  bus.P_Data, 0);
        checkOutput("rst_busy",   bus.busy, 0);
        checkStatus("rst");
        rst = 1'b1;
        @(negedge clk);

        // bit_valid while idle must not touch the data word or complete a frame
        bus.bit_valid   = 1'b1;
        bus.sampled_bit = 1'b1;
        repeat (2) @(negedge clk);
        bus.bit_valid = 1'b0;
        checkOutput("idle_pdata", bus.P_Data, 0);
        checkOutput("idle_done",  bus.chk_done, 0);
        checkOutput("idle_busy",  bus.busy, 0);

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].pen, vecs[v].data, vecs[v].pbit,
                          vecs[v].expErr, 1'b0, 1'b1, $sformatf("vec%0d", v));
        end

        // abort after 4 bits, restart with a same-cycle bit_valid that must be dropped
        pulseClr("abort_clr");
        bus.frame_start = 1'b1;
        bus.PAR_TYPE    = M_ODD;
        bus.par_en      = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bit_valid   = 1'b1;
            bus.sampled_bit = 1'b1;
            @(negedge clk);
            bus.bit_valid = 1'b0;
            checkOutput("abort_early", bus.chk_done, 0);
        end
        bus.frame_start = 1'b1;
        bus.PAR_TYPE    = M_EVEN;
        bus.par_en      = 1'b1;
        bus.bit_valid   = 1'b1;
        bus.sampled_bit = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.bit_valid   = 1'b0;
        checkOutput("abort_restart_done", bus.chk_done, 0);
        applyStimulus(M_EVEN, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, "abort_new");

        // counter saturation, then clear coinciding with a new mismatch
        for (int k = 0; k < 5; k++) begin
            applyStimulus(M_EVEN, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, $sformatf("sat%0d", k));
        end
        applyStimulus(M_EVEN, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, "sat_clr");

        for (int r = 0; r < 40; r++) begin
            m  = 2'($urandom);
            p  = 1'($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            pb = 1'($urandom);
            ce = ($urandom_range(0, 7) == 0);
            applyStimulus(m, p, d, pb, refErr(m, p, d, pb), ce, 1'b1, $sformatf("rnd%0d", r));
            if ($urandom_range(0, 9) == 0) pulseClr($sformatf("rnd%0d_clr", r));
        end

        // asynchronous reset in the middle of a data phase
        applyStimulus(M_MARK, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1, "pre_rst");
        bus.frame_start = 1'b1;
        bus.PAR_TYPE    = M_EVEN;
        bus.par_en      = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid   = 1'b1;
            bus.sampled_bit = 1'b1;
            @(negedge clk);
            bus.bit_valid = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        mdlSticky = 1'b0;
        mdlCnt    = 0;
        checkOutput("mid_rst_busy",  bus.busy, 0);
        checkOutput("mid_rst_pdata", bus.P_Data, 0);
        checkOutput("mid_rst_done",  bus.chk_done, 0);
        checkOutput("mid_rst_perr",  bus.par_err, 0);
        checkStatus("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(M_EVEN, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst_ok");
        applyStimulus(M_ODD,  1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, "post_rst_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_par_chk.md
Name: uart_rx_par_chk

Overview:
- Parametrised, bit-serial parity checker for the UART RX path.
- Accumulates parity on the fly as the sampler delivers data bits, LSB first, so no parallel data word is needed for the check.
- Compares the accumulated parity against the received parity bit.
- Supports four parity modes and a configurable data width.
- Reports a per-frame error pulse, a sticky error flag and a saturating error count to the RX FSM and status logic.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start-bit centre; (re)arms the checker.
- PAR_TYPE  in  2  parity mode: 00 even, 01 odd, 10 mark (parity bit = 1), 11 space (parity bit = 0). Sampled only on frame_start.
- par_en  in  1  parity bit present in the frame. Sampled only on frame_start.
- bit_valid  in  1  sampled_bit is valid this cycle (one pulse per bit).
- sampled_bit  in  1  current data or parity bit from the sampler.
- clr_err  in  1  synchronous clear of the sticky flag and the counter.
- P_Data  out  DATA_W  assembled data word, LSB first; stable after chk_done.
- chk_done  out  1  one-cycle pulse: frame check complete; par_err valid in the same cycle.
- par_err  out  1  parity mismatch for the completed frame; meaningful only when chk_done=1.
- par_err_sticky  out  1  set on any mismatch; held until clr_err.
- err_cnt  out  CNT_W  saturating count of mismatching frames.
- busy  out  1  high in DATA or PARITY state.

Behaviour:
- Reset (rst=0): state IDLE, bit counter 0, parity accumulator 0, P_Data 0, chk_done 0, par_err 0, par_err_sticky 0, err_cnt 0, latched mode = even, latched par_en = 0.
- FSM states: IDLE, DATA, PARITY.
- IDLE: bit_valid is ignored.
  - On frame_start: latch PAR_TYPE and par_en, clear the accumulator and bit counter, go to DATA.
- DATA: on each bit_valid:
  - accumulator <= accumulator ^ sampled_bit.
  - P_Data[cnt] <= sampled_bit; cnt increments.
  - On the bit with cnt = DATA_W-1: if latched par_en = 1, go to PARITY; otherwise go to IDLE and pulse chk_done with par_err = 0.
- PARITY: on bit_valid, compute the expected bit and compare:
  - Expected bit: even = accumulator; odd = ~accumulator; mark = 1; space = 0.
  - par_err <= sampled_bit ^ expected.
  - chk_done <= 1; go to IDLE.
- Latency: chk_done and par_err are registered and assert on the cycle after the final bit_valid. chk_done is a single-cycle pulse.
- par_err holds its value until the next chk_done. It is never updated outside a chk_done cycle.
- Mismatch side effects: par_err_sticky <= 1. err_cnt increments and saturates at all-ones (no wrap).
- clr_err: clears par_err_sticky and err_cnt next cycle.
  - Simultaneous clr_err and new mismatch: the result is sticky = 1 and err_cnt = 1.
- frame_start in DATA or PARITY: abort the current frame with no chk_done and no error update. Re-latch mode and par_en, clear the accumulator and counter, stay in or go to DATA.
- frame_start and bit_valid in the same cycle: frame_start wins; that bit_valid is dropped.
- PAR_TYPE and par_en changes mid-frame have no effect; only the values latched at frame_start are used.
- Counter width is ceil(log2(DATA_W)) bits; the compare is against the constant DATA_W-1.

Optional Feature:
- Macro UART_PAR_ERR_CNT_EN.
- Defined: err_cnt is implemented as specified.
- Undefined: no counter flops; err_cnt is tied to 0; par_err_sticky and clr_err behaviour are unchanged.

Test Plan:
- Even parity, DATA_W=8, bits 0xA5 LSB first, parity bit 0 -> chk_done one cycle after the parity bit_valid, par_err=0, P_Data=0xA5, err_cnt=0.
- Odd parity, data 0x0F, parity bit 0 (expected 1) -> par_err=1, par_err_sticky=1, err_cnt=1. Follow with odd 0x0F, parity 1 -> par_err=0, sticky stays 1.
- Mark/space: mark with parity 0 -> par_err=1; space with parity 0 -> par_err=0. par_en=0 frame with data 0x3C -> chk_done after the 8th bit, par_err=0.
- frame_start after 4 data bits -> no chk_done. The new frame 0x55 with even parity 0 completes with par_err=0, and the aborted frame does not count.
- CNT_W=2: force 5 error frames -> err_cnt saturates at 3. clr_err on the same cycle as a 6th error -> err_cnt=1, sticky=1.
- rst asserted mid-DATA -> all outputs 0 immediately (asynchronous); busy=0; a subsequent frame checks correctly.
